// File: rtl/dpram_be_clr_if.sv
// Bus bundle for dpram_be_clr: both RAM ports, clear control and status flags.
// master drives requests (CPU/DMA side); slave is the RAM itself.
interface dpram_be_clr_if #(
  parameter int DATAWIDTH = 16,
  parameter int BYTEWIDTH = 8,
  parameter int ADDRWIDTH = 10
) ();
  localparam int NBYTES = DATAWIDTH / BYTEWIDTH;

  logic                 clear_req;
  logic                 busy;
  logic [ADDRWIDTH-1:0] address_a;
  logic [ADDRWIDTH-1:0] address_b;
  logic [DATAWIDTH-1:0] data_a;
  logic [DATAWIDTH-1:0] data_b;
  logic                 wren_a;
  logic                 wren_b;
  logic [NBYTES-1:0]    byteena_a;
  logic [NBYTES-1:0]    byteena_b;
  logic [DATAWIDTH-1:0] q_a;
  logic [DATAWIDTH-1:0] q_b;
  logic                 collision;
  logic                 parity_err_a;
  logic                 parity_err_b;

  modport master (
    output clear_req, address_a, address_b, data_a, data_b,
           wren_a, wren_b, byteena_a, byteena_b,
    input  busy, q_a, q_b, collision, parity_err_a, parity_err_b
  );

  modport slave (
    input  clear_req, address_a, address_b, data_a, data_b,
           wren_a, wren_b, byteena_a, byteena_b,
    output busy, q_a, q_b, collision, parity_err_a, parity_err_b
  );
endinterface

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, read-during-write mode, optional output
// register, A-wins collision arbitration and a clear engine. Parity: DPRAM_PARITY_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RESET_HOLD | reset just released; picks auto-clear or idle on first clock
// IDLE       | normal operation, waiting for clear_req
// CLEAR      | writes CLEAR_VALUE to address cnt_q, one word per cycle
module dpram_be_clr #(
  parameter int                   DATAWIDTH      = 16,
  parameter int                   BYTEWIDTH      = 8,
  parameter int                   ADDRWIDTH      = 10,
  parameter int                   NUMWORDS       = 1 << ADDRWIDTH,
  parameter int                   RDW_MODE       = 0,
  parameter int                   OUT_REG        = 0,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATAWIDTH-1:0] CLEAR_VALUE    = '0,
  parameter string                MEM_INIT_FILE  = ""
) (
  input logic          clock,
  input logic          reset_n,
  dpram_be_clr_if.slave bus
);
  localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUMWORDS - 1);
  localparam logic CLR_RST = (CLEAR_ON_RESET != 0);

  typedef enum logic [1:0] {RESET_HOLD, IDLE, CLEAR} state_t;

  logic [DATAWIDTH-1:0] mem [NUMWORDS];

  state_t               state_q;
  logic [ADDRWIDTH-1:0] cnt_q;
  logic                 busy_q;

  logic                 valid_a, valid_b, same_addr;
  logic [NBYTES-1:0]    we_a, we_b;
  logic [DATAWIDTH-1:0] old_a, old_b, merge_a, merge_b;
  logic [DATAWIDTH-1:0] rd_a_d, rd_b_d, rd_a_q, rd_b_q;
  logic                 perr_a_d, perr_b_d, perr_a_q, perr_b_q;
  logic                 col_d, col_q;

`ifdef DPRAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [NUMWORDS];
  logic [NBYTES-1:0] old_pa, old_pb, merge_pa, merge_pb;

  function automatic logic [NBYTES-1:0] lane_par(input logic [DATAWIDTH-1:0] w);
    lane_par = '0;
    for (int i = 0; i < NBYTES; i++) lane_par[i] = ^w[i*BYTEWIDTH +: BYTEWIDTH];
  endfunction
`endif

  assign valid_a   = ({1'b0, bus.address_a} < (ADDRWIDTH+1)'(NUMWORDS));
  assign valid_b   = ({1'b0, bus.address_b} < (ADDRWIDTH+1)'(NUMWORDS));
  assign same_addr = (bus.address_a == bus.address_b);

  always_comb begin
    we_a    = '0;
    we_b    = '0;
    old_a   = valid_a ? mem[bus.address_a] : '0;
    old_b   = valid_b ? mem[bus.address_b] : '0;
    merge_a = old_a;
    merge_b = old_b;
    for (int i = 0; i < NBYTES; i++) begin
      we_a[i] = !busy_q && bus.wren_a && bus.byteena_a[i] && valid_a;
      // Port A owns any lane both ports enable on the same word.
      we_b[i] = !busy_q && bus.wren_b && bus.byteena_b[i] && valid_b &&
                !(same_addr && we_a[i]);
      if (we_a[i]) merge_a[i*BYTEWIDTH +: BYTEWIDTH] = bus.data_a[i*BYTEWIDTH +: BYTEWIDTH];
      if (we_b[i]) merge_b[i*BYTEWIDTH +: BYTEWIDTH] = bus.data_b[i*BYTEWIDTH +: BYTEWIDTH];
    end
    rd_a_d = (RDW_MODE == 0) ? merge_a : old_a;
    rd_b_d = (RDW_MODE == 0) ? merge_b : old_b;
    col_d  = !busy_q && bus.wren_a && bus.wren_b && valid_a && valid_b && same_addr &&
             |(bus.byteena_a & bus.byteena_b);
  end

`ifdef DPRAM_PARITY_EN
  always_comb begin
    old_pa   = valid_a ? par_mem[bus.address_a] : '0;
    old_pb   = valid_b ? par_mem[bus.address_b] : '0;
    merge_pa = old_pa;
    merge_pb = old_pb;
    for (int i = 0; i < NBYTES; i++) begin
      if (we_a[i]) merge_pa[i] = ^bus.data_a[i*BYTEWIDTH +: BYTEWIDTH];
      if (we_b[i]) merge_pb[i] = ^bus.data_b[i*BYTEWIDTH +: BYTEWIDTH];
    end
    perr_a_d = |(lane_par(rd_a_d) ^ ((RDW_MODE == 0) ? merge_pa : old_pa));
    perr_b_d = |(lane_par(rd_b_d) ^ ((RDW_MODE == 0) ? merge_pb : old_pb));
  end
`else
  assign perr_a_d = 1'b0;
  assign perr_b_d = 1'b0;
`endif

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= CLEAR_VALUE;
`ifdef DPRAM_PARITY_EN
      par_mem[cnt_q] <= lane_par(CLEAR_VALUE);
`endif
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (we_a[i]) begin
          mem[bus.address_a][i*BYTEWIDTH +: BYTEWIDTH] <= bus.data_a[i*BYTEWIDTH +: BYTEWIDTH];
`ifdef DPRAM_PARITY_EN
          par_mem[bus.address_a][i] <= ^bus.data_a[i*BYTEWIDTH +: BYTEWIDTH];
`endif
        end
        if (we_b[i]) begin
          mem[bus.address_b][i*BYTEWIDTH +: BYTEWIDTH] <= bus.data_b[i*BYTEWIDTH +: BYTEWIDTH];
`ifdef DPRAM_PARITY_EN
          par_mem[bus.address_b][i] <= ^bus.data_b[i*BYTEWIDTH +: BYTEWIDTH];
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_HOLD;
      cnt_q   <= '0;
      busy_q  <= CLR_RST;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          state_q <= CLR_RST ? CLEAR : IDLE;
          busy_q  <= CLR_RST;
          cnt_q   <= '0;
        end
        IDLE: begin
          if (bus.clear_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
      col_q    <= 1'b0;
    end else begin
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      perr_a_q <= perr_a_d;
      perr_b_q <= perr_b_d;
      col_q    <= col_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATAWIDTH-1:0] q_a_q, q_b_q;
    logic                 pe_a_q, pe_b_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_a_q  <= '0;
        q_b_q  <= '0;
        pe_a_q <= 1'b0;
        pe_b_q <= 1'b0;
      end else begin
        q_a_q  <= rd_a_q;
        q_b_q  <= rd_b_q;
        pe_a_q <= perr_a_q;
        pe_b_q <= perr_b_q;
      end
    end
    assign bus.q_a          = q_a_q;
    assign bus.q_b          = q_b_q;
    assign bus.parity_err_a = pe_a_q;
    assign bus.parity_err_b = pe_b_q;
  end else begin : g_noreg
    assign bus.q_a          = rd_a_q;
    assign bus.q_b          = rd_b_q;
    assign bus.parity_err_a = perr_a_q;
    assign bus.parity_err_b = perr_b_q;
  end

  assign bus.busy      = busy_q;
  assign bus.collision = col_q;
endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: dut0 = defaults (1024 words, new-data RDW, no out reg);
// dut1 = 12 words, old-data RDW, output register, no auto-clear.
module tb_dpram_be_clr;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst0_n, rst1_n;
  int   n_pass = 0;
  int   n_tot  = 0;

  dpram_be_clr_if if0 ();
  dpram_be_clr_if #(.DATAWIDTH(16), .BYTEWIDTH(8), .ADDRWIDTH(4)) if1 ();

  dpram_be_clr dut0 (.clock(clock), .reset_n(rst0_n), .bus(if0));
  dpram_be_clr #(
    .ADDRWIDTH(4), .NUMWORDS(12), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(0),
    .CLEAR_VALUE(16'h0000)
  ) dut1 (.clock(clock), .reset_n(rst1_n), .bus(if1));

  typedef struct {
    logic        wa;  logic [9:0] aa; logic [15:0] da; logic [1:0] bea;
    logic        wb;  logic [9:0] ab; logic [15:0] db; logic [1:0] beb;
    logic [15:0] eqa; logic [15:0] eqb; logic ecol;
  } vec_t;
  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle0();
    if0.clear_req = 0; if0.wren_a = 0; if0.wren_b = 0;
    if0.byteena_a = 2'b00; if0.byteena_b = 2'b00;
    if0.data_a = '0; if0.data_b = '0;
  endtask

  task automatic idle1();
    if1.clear_req = 0; if1.wren_a = 0; if1.wren_b = 0;
    if1.byteena_a = 2'b00; if1.byteena_b = 2'b00;
    if1.data_a = '0; if1.data_b = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // wa aa da bea | wb ab db beb | q_a q_b collision
    vt[0]  = '{1'b1, 10'd5,  16'h1234, 2'b11, 1'b0, 10'd5,  16'h0000, 2'b00, 16'h1234, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 10'd5,  16'hABCD, 2'b10, 1'b0, 10'd5,  16'h0000, 2'b00, 16'hAB34, 16'h1234, 1'b0};
    vt[2]  = '{1'b0, 10'd5,  16'h0000, 2'b00, 1'b0, 10'd5,  16'h0000, 2'b00, 16'hAB34, 16'hAB34, 1'b0};
    vt[3]  = '{1'b0, 10'd7,  16'h0000, 2'b00, 1'b1, 10'd7,  16'h1111, 2'b11, 16'h0000, 16'h1111, 1'b0};
    vt[4]  = '{1'b1, 10'd7,  16'h2222, 2'b11, 1'b0, 10'd7,  16'h0000, 2'b00, 16'h2222, 16'h1111, 1'b0};
    vt[5]  = '{1'b1, 10'd3,  16'hAAAA, 2'b01, 1'b1, 10'd3,  16'hBBBB, 2'b10, 16'h00AA, 16'hBB00, 1'b0};
    vt[6]  = '{1'b0, 10'd3,  16'h0000, 2'b00, 1'b0, 10'd3,  16'h0000, 2'b00, 16'hBBAA, 16'hBBAA, 1'b0};
    vt[7]  = '{1'b1, 10'd3,  16'hAAAA, 2'b11, 1'b1, 10'd3,  16'hBBBB, 2'b11, 16'hAAAA, 16'hBBAA, 1'b1};
    vt[8]  = '{1'b0, 10'd3,  16'h0000, 2'b00, 1'b0, 10'd3,  16'h0000, 2'b00, 16'hAAAA, 16'hAAAA, 1'b0};
    vt[9]  = '{1'b1, 10'd20, 16'h5555, 2'b11, 1'b1, 10'd21, 16'h6666, 2'b11, 16'h5555, 16'h6666, 1'b0};
    vt[10] = '{1'b0, 10'd21, 16'h0000, 2'b00, 1'b0, 10'd20, 16'h0000, 2'b00, 16'h6666, 16'h5555, 1'b0};
    vt[11] = '{1'b1, 10'd20, 16'hFFFF, 2'b00, 1'b0, 10'd20, 16'h0000, 2'b00, 16'h5555, 16'h5555, 1'b0};
    vt[12] = '{1'b1, 10'd40, 16'h00CC, 2'b01, 1'b1, 10'd40, 16'h00DD, 2'b01, 16'h00CC, 16'h0000, 1'b1};
    vt[13] = '{1'b0, 10'd40, 16'h0000, 2'b00, 1'b0, 10'd40, 16'h0000, 2'b00, 16'h00CC, 16'h00CC, 1'b0};
    vt[14] = '{1'b1, 10'd50, 16'hAAAA, 2'b01, 1'b1, 10'd50, 16'hBBBB, 2'b11, 16'h00AA, 16'hBB00, 1'b1};
    vt[15] = '{1'b0, 10'd50, 16'h0000, 2'b00, 1'b0, 10'd50, 16'h0000, 2'b00, 16'hBBAA, 16'hBBAA, 1'b0};

    idle0(); idle1();
    if0.address_a = '0; if0.address_b = '0; if1.address_a = '0; if1.address_b = '0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    cyc(); cyc();
    check("rst_q_a", if0.q_a, 16'h0000);
    check("rst_q_b", if0.q_b, 16'h0000);
    check("rst_busy_autoclr", if0.busy, 1'b1);
    check("rst_collision", if0.collision, 1'b0);
    check("rst_busy_noauto", if1.busy, 1'b0);
    check("rst_q_a_oreg", if1.q_a, 16'h0000);

    // Auto-clear after reset release
    rst0_n = 1'b1; rst1_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (if0.busy) n++; else break;
    end
    check("autoclear_busy_cycles", n, 1024);
    if0.address_a = 10'd1023; if0.address_b = 10'd512;
    cyc();
    check("autoclear_read_a", if0.q_a, 16'h0000);
    check("autoclear_read_b", if0.q_b, 16'h0000);
    check("parity_err_a_idle", if0.parity_err_a, 1'b0);

    // Table-driven port behaviour on dut0
    for (int v = 0; v < 16; v++) begin
      if0.wren_a = vt[v].wa; if0.address_a = vt[v].aa; if0.data_a = vt[v].da; if0.byteena_a = vt[v].bea;
      if0.wren_b = vt[v].wb; if0.address_b = vt[v].ab; if0.data_b = vt[v].db; if0.byteena_b = vt[v].beb;
      cyc();
      check($sformatf("vec%0d_q_a", v), if0.q_a, vt[v].eqa);
      check($sformatf("vec%0d_q_b", v), if0.q_b, vt[v].eqb);
      check($sformatf("vec%0d_collision", v), if0.collision, vt[v].ecol);
    end
    idle0();

    // clear_req: second request and a user write while busy are both ignored
    if0.clear_req = 1'b1;
    cyc();
    if0.clear_req = 1'b0;
    check("clear_busy_rise", if0.busy, 1'b1);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      if (n == 300) begin
        if0.clear_req = 1'b1; if0.wren_a = 1'b1; if0.address_a = 10'd200;
        if0.data_a = 16'h7777; if0.byteena_a = 2'b11;
      end else idle0();
      cyc();
      if (if0.busy) n++; else break;
    end
    idle0();
    check("clear_busy_cycles", n, 1024);
    if0.address_a = 10'd200; if0.address_b = 10'd5;
    cyc();
    check("write_during_busy_dropped", if0.q_a, 16'h0000);
    check("cleared_addr5", if0.q_b, 16'h0000);
    check("no_queued_clear", if0.busy, 1'b0);

    // Reset at cnt=100 aborts; restart clears from 0 for a full NUMWORDS
    if0.wren_a = 1'b1; if0.address_a = 10'd500; if0.data_a = 16'h4242; if0.byteena_a = 2'b11;
    cyc();
    idle0();
    if0.clear_req = 1'b1;
    cyc();
    if0.clear_req = 1'b0;
    repeat (100) cyc();
    rst0_n = 1'b0;
    #1;
    check("abort_busy_in_reset", if0.busy, 1'b1);
    check("abort_q_a_reset", if0.q_a, 16'h0000);
    cyc();
    rst0_n = 1'b1;
    if0.address_a = 10'd500;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (i == 0) check("mem_kept_over_reset", if0.q_a, 16'h4242);
      if (if0.busy) n++; else break;
    end
    check("restart_busy_cycles", n, 1024);
    cyc();
    check("restart_cleared_500", if0.q_a, 16'h0000);

    // dut1: manual clear of a 12-word RAM
    check("noauto_idle_busy", if1.busy, 1'b0);
    if1.clear_req = 1'b1;
    cyc();
    if1.clear_req = 1'b0;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (if1.busy) n++; else break;
    end
    check("clear12_busy_cycles", n, 12);

    // Old-data read-during-write, two-cycle latency
    if1.wren_a = 1'b1; if1.address_a = 4'd7; if1.data_a = 16'h1111; if1.byteena_a = 2'b11;
    cyc();
    if1.data_a = 16'h2222; if1.address_b = 4'd7;
    cyc();
    idle1(); if1.address_a = 4'd0; if1.address_b = 4'd0;
    cyc();
    check("rdw_old_q_a", if1.q_a, 16'h1111);
    check("rdw_cross_q_b", if1.q_b, 16'h1111);
    if1.address_a = 4'd7;
    cyc(); cyc();
    check("rdw_old_then_new", if1.q_a, 16'h2222);

    // Output-register latency on address 9
    if1.wren_a = 1'b1; if1.address_a = 4'd9; if1.data_a = 16'h0909; if1.byteena_a = 2'b11;
    cyc();
    idle1(); if1.address_a = 4'd0;
    cyc(); cyc();
    if1.address_a = 4'd9;
    cyc();
    check("oreg_not_early", if1.q_a, 16'h0000);
    if1.address_a = 4'd0;
    cyc();
    check("oreg_two_cycles", if1.q_a, 16'h0909);
    cyc();
    check("oreg_next", if1.q_a, 16'h0000);

    // Out-of-range addresses (depth 12): writes ignored, reads 0, no collision
    if1.wren_a = 1'b1; if1.address_a = 4'd13; if1.data_a = 16'hDEAD; if1.byteena_a = 2'b11;
    if1.wren_b = 1'b1; if1.address_b = 4'd13; if1.data_b = 16'hBEEF; if1.byteena_b = 2'b11;
    cyc();
    check("oob_no_collision", if1.collision, 1'b0);
    idle1(); if1.address_a = 4'd13; if1.address_b = 4'd1;
    cyc(); cyc();
    check("oob_read_zero", if1.q_a, 16'h0000);
    check("oob_no_alias", if1.q_b, 16'h0000);

`ifdef DPRAM_PARITY_EN
    dut1.par_mem[9][0] = ~dut1.par_mem[9][0];
    if1.address_a = 4'd9;
    cyc();
    if1.address_a = 4'd0;
    cyc();
    check("parity_q_a", if1.q_a, 16'h0909);
    check("parity_err_aligned", if1.parity_err_a, 1'b1);
    cyc();
    check("parity_err_clears", if1.parity_err_a, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
